// File: rtl/nibble_unpacker.sv
// Splits a {b,a} word into its two DW-bit halves, one half per output transfer,
// and flags words whose halves are equal.
module nibble_unpacker #(
  parameter int unsigned DW        = 4,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2*DW-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [DW-1:0]   out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic            out_rep
);

  typedef enum logic [1:0] {StEmpty, StFirst, StSecond} state_e;

  state_e            state_q, state_d;
  logic [2*DW-1:0]   hold_q, hold_d;
  logic [DW-1:0]     out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              out_rep_q, out_rep_d;

  logic [DW-1:0]     in_lo, in_hi, first_in, second_held;
  logic              in_xfer;

  assign in_lo       = in_data[DW-1:0];
  assign in_hi       = in_data[2*DW-1:DW];
  assign first_in    = LSB_FIRST ? in_lo : in_hi;
  assign second_held = LSB_FIRST ? hold_q[2*DW-1:DW] : hold_q[DW-1:0];

  // A new word may enter while the last half of the previous one is leaving.
  assign in_ready = !rst && ((state_q == StEmpty) || ((state_q == StSecond) && out_ready));
  assign in_xfer  = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_rep_d   = out_rep_q;

    unique case (state_q)
      StEmpty: begin
        if (in_xfer) begin
          state_d     = StFirst;
          hold_d      = in_data;
          out_data_d  = first_in;
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          out_rep_d   = (in_hi == in_lo);
        end
      end
      StFirst: begin
        if (out_ready) begin
          state_d    = StSecond;
          out_data_d = second_held;
          out_last_d = 1'b1;
        end
      end
      StSecond: begin
        if (out_ready) begin
          if (in_xfer) begin
            state_d     = StFirst;
            hold_d      = in_data;
            out_data_d  = first_in;
            out_valid_d = 1'b1;
            out_last_d  = 1'b0;
            out_rep_d   = (in_hi == in_lo);
          end else begin
            state_d     = StEmpty;
            out_data_d  = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_rep_d   = 1'b0;
          end
        end
      end
      default: begin
        state_d     = StEmpty;
        out_data_d  = '0;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        out_rep_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StEmpty;
      hold_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_rep_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_rep_q   <= out_rep_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_rep   = out_rep_q;

endmodule
